multicycle_datapath: RTL

// Multi-cycle RISC-V RV32I datapath with internal step sequencer; successor to the single-cycle datapath.

---
 rtl/multicycle_datapath_pkg.sv | 44 ++++
 rtl/multicycle_datapath_sequencer.sv | 106 ++++++++++
 rtl/multicycle_datapath.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multi-cycle RV32I datapath: sequencer states and
// the control-field encodings driven by the external decoder.
package multicycle_datapath_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } mc_state_e;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Load select follows the RV32I load funct3 so the decoder can pass it straight through.
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

endpackage

// File: rtl/multicycle_datapath_sequencer.sv
// Step sequencer for the multi-cycle datapath: state register plus the
// per-state register enables and memory request controls.
module mc_sequencer
    import multicycle_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic       RegWrite,
    input  logic       MemWrite,
    input  logic [1:0] ResultSrc,
    input  logic       Illegal,
    output mc_state_e  state,
    output logic       ir_we,
    output logic       operand_we,
    output logic       exec_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel_alu,
    output logic       instr_done,
    output logic       trap
);

    mc_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ir_we        = 1'b0;
        operand_we   = 1'b0;
        exec_we      = 1'b0;
        mdr_we       = 1'b0;
        rf_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel_alu = 1'b0;
        instr_done   = 1'b0;
        trap         = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                operand_we = 1'b1;
                state_nxt  = Illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                exec_we = 1'b1;
                if (MemWrite || ResultSrc == RES_MDR) begin
                    state_nxt = S_MEM;
                end else if (RegWrite) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt  = S_FETCH;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_we       = MemWrite;
                addr_sel_alu = 1'b1;
                if (mem_ready) begin
                    if (MemWrite) begin
                        state_nxt  = S_FETCH;
                        instr_done = 1'b1;
                    end else begin
                        mdr_we    = 1'b1;
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = RegWrite;
                instr_done = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
        // Reset kills any in-flight request or write in the same cycle it is seen.
        if (rst) begin
            ir_we      = 1'b0;
            operand_we = 1'b0;
            exec_we    = 1'b0;
            mdr_we     = 1'b0;
            rf_we      = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I datapath: architectural registers, inter-step registers,
// ALU, immediate/load extension and the unified memory port.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int                N_Bits   = 32,
    parameter logic [N_Bits-1:0] RESET_PC = '0,
    parameter int                NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ImmSrc,
    input  logic              ALUSrcA,
    input  logic              ALUSrcB,
    input  logic [1:0]        ResultSrc,
    input  logic              RegWrite,
    input  logic [2:0]        Loadtype,
    input  logic              Jalr,
    input  logic              PCSrc,
    input  logic              MemWrite,
    input  logic [3:0]        ALUControl,
    input  logic              Illegal,
    input  logic [N_Bits-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [N_Bits-1:0] Instr,
    output logic              Zero,
    output logic              Negflag,
    output logic              Unsigned_less_than,
    output logic              mem_req,
    output logic              mem_we,
    output logic [N_Bits-1:0] mem_addr,
    output logic [N_Bits-1:0] mem_wdata,
    output logic [N_Bits-1:0] PC,
    output logic [2:0]        state_o,
    output logic              instr_done,
    output logic              trap
);

    localparam int AW  = $clog2(NUM_REGS);
    localparam int SHW = $clog2(N_Bits);

    function automatic logic signed [31:0] imm_gen(input logic [2:0] sel, input logic [31:7] ir);
        case (sel)
            IMM_S:   imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            IMM_U:   imm_gen = {ir[31:12], 12'b0};
            default: imm_gen = {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

    function automatic logic [N_Bits-1:0] load_ext(input logic [2:0] sel, input logic [N_Bits-1:0] d);
        case (sel)
            LD_B:    load_ext = N_Bits'($signed(d[7:0]));
            LD_H:    load_ext = N_Bits'($signed(d[15:0]));
            LD_BU:   load_ext = N_Bits'(d[7:0]);
            LD_HU:   load_ext = N_Bits'(d[15:0]);
            default: load_ext = d;
        endcase
    endfunction

    function automatic logic [N_Bits-1:0] alu_op(input logic [3:0] op,
                                                input logic [N_Bits-1:0] a,
                                                input logic [N_Bits-1:0] b);
        logic signed [N_Bits-1:0] sa;
        logic signed [N_Bits-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_SUB:   alu_op = a - b;
            ALU_AND:   alu_op = a & b;
            ALU_OR:    alu_op = a | b;
            ALU_XOR:   alu_op = a ^ b;
            ALU_SLT:   alu_op = {{(N_Bits-1){1'b0}}, (sa < sb)};
            ALU_SLTU:  alu_op = {{(N_Bits-1){1'b0}}, (a < b)};
            ALU_SLL:   alu_op = a << b[SHW-1:0];
            ALU_SRL:   alu_op = a >> b[SHW-1:0];
            ALU_SRA:   alu_op = sa >>> b[SHW-1:0];
            ALU_PASSB: alu_op = b;
            default:   alu_op = a + b;
        endcase
    endfunction

    mc_state_e state;
    logic ir_we, operand_we, exec_we, mdr_we, rf_we, addr_sel_alu;

    logic [N_Bits-1:0] ir, old_pc, a_reg, b_reg, alu_out, mdr;
    logic [N_Bits-1:0] regs [NUM_REGS];
    logic [N_Bits-1:0] rd1, rd2, src_a, src_b, alu_res, imm_ext, result, wb_val;
    logic signed [31:0] imm32;
    logic [AW-1:0] rs1, rs2, rd;

    mc_sequencer u_seq (
        .clk          (clk),
        .rst          (rst),
        .mem_ready    (mem_ready),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .ResultSrc    (ResultSrc),
        .Illegal      (Illegal),
        .state        (state),
        .ir_we        (ir_we),
        .operand_we   (operand_we),
        .exec_we      (exec_we),
        .mdr_we       (mdr_we),
        .rf_we        (rf_we),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel_alu (addr_sel_alu),
        .instr_done   (instr_done),
        .trap         (trap)
    );

    assign rs1 = ir[15 +: AW];
    assign rs2 = ir[20 +: AW];
    assign rd  = ir[7 +: AW];
    assign rd1 = (rs1 == '0) ? '0 : regs[rs1];
    assign rd2 = (rs2 == '0) ? '0 : regs[rs2];

    assign imm32   = imm_gen(ImmSrc, ir[31:7]);
    assign imm_ext = N_Bits'(imm32);

    assign src_a   = ALUSrcA ? old_pc : a_reg;
    assign src_b   = ALUSrcB ? imm_ext : b_reg;
    assign alu_res = alu_op(ALUControl, src_a, src_b);

    assign Zero               = (alu_res == '0);
    assign Negflag            = alu_res[N_Bits-1];
    assign Unsigned_less_than = (src_a < src_b);

    always_comb begin
        result = alu_out;
        case (ResultSrc)
            RES_MDR: result = mdr;
            RES_PC4: result = old_pc + N_Bits'(4);
            RES_IMM: result = imm_ext;
            default: result = alu_out;
        endcase
    end
    assign wb_val = load_ext(Loadtype, result);

    always_ff @(posedge clk) begin
        if (rst) begin
            PC      <= RESET_PC;
            ir      <= '0;
            old_pc  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if (ir_we) begin
                ir     <= mem_rdata;
                old_pc <= PC;
                PC     <= PC + N_Bits'(4);
            end
            if (operand_we) begin
                a_reg <= rd1;
                b_reg <= rd2;
            end
            if (exec_we) begin
                alu_out <= alu_res;
                // JALR target clears bit 0; branches/JAL are PC-relative to the fetched PC.
                if (Jalr)       PC <= {alu_res[N_Bits-1:1], 1'b0};
                else if (PCSrc) PC <= old_pc + imm_ext;
            end
            if (mdr_we) mdr <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && rd != '0) regs[rd] <= wb_val;
    end

    assign Instr     = ir;
    assign mem_addr  = addr_sel_alu ? alu_out : PC;
    assign mem_wdata = b_reg;
    assign state_o   = state;

endmodule
